// File: rtl/color_mapping_sdiv_50s_42ns_seq.sv
// Sequential signed-by-unsigned restoring divider with C truncation semantics.
// One quotient bit per cycle, valid/ready handshake on operands and result.
module color_mapping_sdiv_50s_42ns_seq #(
  parameter int DIVIDEND_WIDTH = 50,
  parameter int DIVISOR_WIDTH  = 42
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  input  logic                      in_vld,
  output logic                      in_rdy,
  output logic [DIVIDEND_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem,
  output logic                      dbz,
  output logic                      out_vld,
  input  logic                      out_rdy
);

  localparam int CNT_W = $clog2(DIVIDEND_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [DIVIDEND_WIDTH-1:0] r_mag;
  logic                      r_neg;
  logic [DIVISOR_WIDTH-1:0]  r_div;
  logic                      r_zero;
  logic [DIVISOR_WIDTH:0]    r_prem;
  logic [DIVIDEND_WIDTH-1:0] r_quot;
  logic [DIVISOR_WIDTH-1:0]  r_rem;
  logic                      r_dbz;

  logic [DIVIDEND_WIDTH-1:0] w_absDin0;
  logic [DIVISOR_WIDTH:0]    w_shift;
  logic [DIVISOR_WIDTH+1:0]  w_diff;
  logic                      w_qbit;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    case (r_state)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) w_next = CALC;
      end
      CALC: if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: begin
        out_vld = 1'b1;
        if (out_rdy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Unsigned negation maps the most negative dividend onto 2^(W-1) exactly.
  assign w_absDin0 = din0[DIVIDEND_WIDTH-1] ? -din0 : din0;

  // The partial remainder stays below the divisor, so one extra bit holds the shifted value.
  assign w_shift = {r_prem[DIVISOR_WIDTH-1:0], r_mag[DIVIDEND_WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_div};
  assign w_qbit  = ~w_diff[DIVISOR_WIDTH+1];

  // r_mag shifts magnitude bits out at the top while quotient bits enter at the bottom.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_cnt  <= '0;
      r_mag  <= '0;
      r_neg  <= 1'b0;
      r_div  <= '0;
      r_zero <= 1'b0;
      r_prem <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_vld) begin
            r_mag  <= w_absDin0;
            r_neg  <= din0[DIVIDEND_WIDTH-1];
            r_div  <= din1;
            r_zero <= (din1 == '0);
            r_prem <= '0;
            r_cnt  <= CNT_W'(DIVIDEND_WIDTH - 1);
          end
        end
        CALC: begin
          r_prem <= w_qbit ? w_diff[DIVISOR_WIDTH:0] : w_shift;
          r_mag  <= {r_mag[DIVIDEND_WIDTH-2:0], w_qbit};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          if (r_zero) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b1;
          end else begin
            r_quot <= r_neg ? -r_mag : r_mag;
            r_rem  <= r_neg ? -r_prem[DIVISOR_WIDTH-1:0] : r_prem[DIVISOR_WIDTH-1:0];
            r_dbz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign quot = r_quot;
  assign rem  = r_rem;
  assign dbz  = r_dbz;

endmodule

// File: tb/tb_color_mapping_sdiv_50s_42ns_seq.sv
// Scoreboard bench for the sequential divider: expected results are queued at
// acceptance and compared when the DUT hands the result over.
module tb_color_mapping_sdiv_50s_42ns_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [49:0] din0 = '0;
  logic [41:0] din1 = '0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [49:0] quot;
  logic [41:0] rem;
  logic        dbz;
  logic        out_vld;
  logic        out_rdy = 1'b1;

  typedef struct {
    logic [49:0] q;
    logic [41:0] r;
    logic        d;
    longint      acc;
  } exp_t;

  exp_t   sb[$];
  int     errCnt = 0;
  int     checkCnt = 0;
  longint cycleCnt = 0;
  logic   prevVld = 1'b0;
  logic   prevRdy = 1'b0;

  color_mapping_sdiv_50s_42ns_seq dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .din0   (din0),
    .din1   (din1),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .quot   (quot),
    .rem    (rem),
    .dbz    (dbz),
    .out_vld(out_vld),
    .out_rdy(out_rdy)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCnt++;
    if (actual !== expected) begin
      errCnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Waits for in_rdy, presents one operand pair and, if asked, queues the C-semantics result.
  task automatic applyStimulus(input logic [49:0] a, input logic [41:0] b, input bit expectOut,
                               output longint acc);
    bit     ok = 1'b0;
    longint sa, sbv, qq, rr;
    exp_t   e;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (in_rdy) begin
        ok = 1'b1;
        break;
      end
      @(posedge ap_clk); #1;
    end
    if (!ok) begin
      checkOutput("inRdyTimeout", 64'd0, 64'd1);
      return;
    end
    din0 = a;
    din1 = b;
    in_vld = 1'b1;
    @(posedge ap_clk); #1;
    in_vld = 1'b0;
    acc = cycleCnt;
    if (expectOut) begin
      sa  = longint'(signed'(a));
      sbv = longint'({22'b0, b});
      if (sbv == 0) begin
        e.q = '0;
        e.r = '0;
        e.d = 1'b1;
      end else begin
        qq  = sa / sbv;
        rr  = sa % sbv;
        e.q = qq[49:0];
        e.r = rr[41:0];
        e.d = 1'b0;
      end
      e.acc = acc;
      sb.push_back(e);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 400 && sb.size() > 0; i++) begin
      @(posedge ap_clk); #1;
    end
    if (sb.size() > 0) checkOutput("drainTimeout", 64'(sb.size()), 64'd0);
  endtask

  // Result monitor: latency on the rising edge of out_vld, values on handshake.
  always @(negedge ap_clk) begin
    exp_t e;
    if (out_vld && !prevVld) begin
      if (sb.size() == 0) checkOutput("unexpectedVld", 64'd1, 64'd0);
      else                checkOutput("latency", 64'(cycleCnt - sb[0].acc), 64'd51);
      checkOutput("inRdyInDone", 64'(in_rdy), 64'd0);
    end
    if (prevVld && prevRdy) checkOutput("vldPulse", 64'(out_vld), 64'd0);
    if (out_vld && out_rdy && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("quot", 64'(quot), 64'(e.q));
      checkOutput("rem", 64'(rem), 64'(e.r));
      checkOutput("dbz", 64'(dbz), 64'(e.d));
    end
    prevVld <= out_vld;
    prevRdy <= out_rdy;
  end

  initial begin
    longint accA, accB, accTmp;
    logic [63:0] rnd;
    logic [49:0] ra;
    logic [41:0] rb;
    bit seen;

    repeat (3) @(posedge ap_clk);
    #1;
    checkOutput("rstInRdy", 64'(in_rdy), 64'd1);
    checkOutput("rstOutVld", 64'(out_vld), 64'd0);
    checkOutput("rstQuot", 64'(quot), 64'd0);
    checkOutput("rstRem", 64'(rem), 64'd0);
    checkOutput("rstDbz", 64'(dbz), 64'd0);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;

    applyStimulus(50'd1000, 42'd7, 1'b1, accTmp);
    applyStimulus(-50'sd1000, 42'd7, 1'b1, accTmp);
    applyStimulus(-50'sd7, 42'd7, 1'b1, accTmp);
    applyStimulus({1'b1, 49'd0}, 42'd1, 1'b1, accTmp);
    applyStimulus({1'b0, {49{1'b1}}}, {42{1'b1}}, 1'b1, accTmp);
    applyStimulus(50'd12345, 42'd0, 1'b1, accA);
    applyStimulus(50'd20, 42'd3, 1'b1, accB);
    checkOutput("throughput", 64'(accB - accA), 64'd53);
    for (int i = 0; i < 6; i++) begin
      rnd = {$urandom, $urandom};
      ra  = rnd[49:0];
      rnd = {$urandom, $urandom};
      rb  = (i % 2 == 0) ? 42'($urandom_range(1, 1000)) : rnd[41:0];
      applyStimulus(ra, rb, 1'b1, accTmp);
    end
    waitDrain();

    // Backpressure with junk operands held on the input side.
    out_rdy = 1'b0;
    applyStimulus(50'd999, 42'd10, 1'b1, accTmp);
    din0 = 50'd5;
    din1 = 42'd1;
    in_vld = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_vld) begin
        seen = 1'b1;
        break;
      end
      @(posedge ap_clk); #1;
    end
    checkOutput("bpVldSeen", 64'(seen), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk); #1;
      checkOutput("bpQuot", 64'(quot), 64'd99);
      checkOutput("bpRem", 64'(rem), 64'd9);
      checkOutput("bpVld", 64'(out_vld), 64'd1);
      checkOutput("bpInRdy", 64'(in_rdy), 64'd0);
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    @(posedge ap_clk); #1;
    checkOutput("bpIdleInRdy", 64'(in_rdy), 64'd1);
    checkOutput("bpIdleVld", 64'(out_vld), 64'd0);
    waitDrain();

    // Asynchronous reset in the middle of CALC.
    applyStimulus(50'd777, 42'd5, 1'b0, accTmp);
    repeat (20) @(posedge ap_clk);
    #2;
    ap_rst = 1'b1;
    #1;
    checkOutput("midRstInRdy", 64'(in_rdy), 64'd1);
    checkOutput("midRstVld", 64'(out_vld), 64'd0);
    checkOutput("midRstQuot", 64'(quot), 64'd0);
    checkOutput("midRstRem", 64'(rem), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    applyStimulus(50'd100, 42'd10, 1'b1, accTmp);
    waitDrain();
    repeat (5) @(posedge ap_clk);

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/color_mapping_sdiv_50s_42ns_seq.md
# color_mapping_sdiv_50s_42ns_seq

Sequential signed-by-unsigned divider for the colour-mapping datapath. It is the inverse of the 9s × 42ns → 50 scaling multiply: it takes a 50-bit signed scaled value and the 42-bit unsigned scale factor, and recovers the quotient and remainder over a fixed number of cycles. It sits between the accumulated-intensity path and the palette index logic, using a valid/ready handshake on both sides.

## Interface
- DIVIDEND_WIDTH, 50, width of signed dividend and of the signed quotient
- DIVISOR_WIDTH, 42, width of unsigned divisor and of the signed remainder
- ap_clk  in  1  clock; all state changes on the rising edge
- ap_rst  in  1  reset; asynchronous, active-high
- din0  in  DIVIDEND_WIDTH  signed dividend (two's complement)
- din1  in  DIVISOR_WIDTH  unsigned divisor
- in_vld  in  1  operands valid
- in_rdy  out  1  block can accept operands
- quot  out  DIVIDEND_WIDTH  signed quotient
- rem  out  DIVISOR_WIDTH  signed remainder (two's complement)
- dbz  out  1  divide-by-zero flag, qualified by out_vld
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accepts result

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset forces IDLE.
- IDLE: in_rdy=1. On in_vld=1, the block latches the following and enters CALC with the iteration counter set to DIVIDEND_WIDTH-1:
  - |din0| as an unsigned DIVIDEND_WIDTH value; -2^49 maps to 2^49.
  - the din0 sign bit.
  - din1.
  - a zero flag set when din1==0.
- CALC: performs one restoring step per cycle, MSB first.
  - Shift the partial remainder (DIVISOR_WIDTH+1 bits) left, bringing in the next magnitude bit.
  - Subtract the divisor if the result is non-negative, and shift the result bit into the quotient.
  - The counter decrements each cycle. At counter==0 the FSM moves to FIX.
- FIX: applies C truncation semantics and enters DONE.
  - If the dividend was negative, negate both the quotient and the remainder.
  - The quotient rounds toward zero.
  - The remainder takes the sign of the dividend, with |rem| < din1.
- Divide by zero: latency is unchanged. In FIX, quot=0, rem=0 and dbz=1. Otherwise dbz=0.
- DONE: out_vld=1. quot, rem and dbz stay stable until out_rdy=1. On the out_rdy edge the FSM returns to IDLE.
  - in_rdy is 0 in DONE, so a new operand is never accepted in the same cycle a result is consumed.
- Operands presented while in_rdy=0 are ignored. The block does not queue them.
- Range: |quot| ≤ |din0| for din1 ≥ 1, so the quotient always fits in DIVIDEND_WIDTH signed bits. No saturation logic.

## Timing
- Reset values: in_rdy=1, out_vld=0, quot=0, rem=0, dbz=0, FSM=IDLE, counter=0.
- Acceptance happens at edge k (in_vld & in_rdy).
  - CALC occupies edges k+1 … k+DIVIDEND_WIDTH.
  - FIX occurs at edge k+DIVIDEND_WIDTH+1.
  - out_vld is high from edge k+DIVIDEND_WIDTH+1, which is 51 cycles with default parameters.
- With out_rdy held at 1:
  - out_vld is high for exactly 1 cycle.
  - in_rdy rises the cycle after.
  - Throughput is one operation per DIVIDEND_WIDTH+3 cycles.
- in_rdy and out_vld are registered outputs, decoded directly from the state register. There is no combinational path from in_vld or out_rdy to any output.
- If ap_rst asserts mid-CALC, mid-FIX or in DONE:
  - All outputs take their reset values immediately, without waiting for a clock edge.
  - The partial result is discarded and no out_vld pulse is produced.
- out_rdy asserted during IDLE, CALC or FIX has no effect.

## Test plan
- Positive division: din0=1000, din1=7, out_rdy=1 → quot=142, rem=6, dbz=0. out_vld rises 51 cycles after acceptance and lasts 1 cycle.
- Negative dividend: din0=-1000, din1=7 → quot=-142, rem=-6. Also din0=-7, din1=7 → quot=-1, rem=0.
- Extremes:
  - din0=-2^49, din1=1 → quot=-2^49, rem=0.
  - din0=2^49-1, din1=2^42-1 → quot=128, rem=127.
- Divide by zero: din0=12345, din1=0 → dbz=1, quot=0, rem=0, same 51-cycle latency. The next operation (20/3) gives dbz=0, quot=6, rem=2.
- Backpressure:
  - Hold out_rdy=0 for 10 cycles after out_vld rises → outputs remain stable and in_rdy stays 0.
  - Operands driven with in_vld=1 during CALC/DONE are ignored.
  - Releasing out_rdy returns the FSM to IDLE one cycle later.
- Reset mid-operation: assert ap_rst 20 cycles into CALC → in_rdy=1 and out_vld=0 immediately. After release, a fresh 100/10 operation gives quot=10, rem=0.
